// File: rtl/i2c_axis_target.sv
//==============================================================================
// Module   : i2c_axis_target
// Purpose  : I2C target (slave) write receiver. Watches SCL/SDA, acknowledges
//            write transactions to TARGET_ADDR and packs the received data
//            bytes (first byte in the MSBs) into AXI-Stream words.
//            SDA is only ever pulled low as an open-drain ACK; SCL is never
//            driven.
// Ports    : clk, arst         - system clock (>= 16x SCL), async active-high reset
//            scl_i, sda_i      - raw, asynchronous bus pad inputs
//            sda_oe            - 1 pulls SDA low (ACK), 0 releases
//            m_axis_tvalid/tready/tdata - received word stream
//            busy              - addressed transaction in progress
//            err               - 1-cycle pulse: overflow NACK / dropped partial word
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module i2c_axis_target #(
  parameter logic [6:0] TARGET_ADDR     = 7'h50,
  parameter int         AXIS_DATA_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       arst,
  input  logic                       scl_i,
  input  logic                       sda_i,
  output logic                       sda_oe,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                       busy,
  output logic                       err
);

  localparam int             NBYTES    = AXIS_DATA_WIDTH / 8;
  localparam int             BCW       = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(NBYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ADDR     = 3'd1,
    S_ADDR_ACK = 3'd2,
    S_DATA     = 3'd3,
    S_DATA_ACK = 3'd4,
    S_IGNORE   = 3'd5
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronisers plus one history stage. Reset to 1 (idle bus) so the
  // release of reset can never look like a START.
  // ---------------------------------------------------------------------------
  logic scl_meta_q, scl_sync_q, scl_prev_q;
  logic sda_meta_q, sda_sync_q, sda_prev_q;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_meta_q <= scl_i;
      scl_sync_q <= scl_meta_q;
      scl_prev_q <= scl_sync_q;
      sda_meta_q <= sda_i;
      sda_sync_q <= sda_meta_q;
      sda_prev_q <= sda_sync_q;
    end
  end

  // Bus events. START/STOP require SCL high on both samples so that an SDA
  // change coinciding with an SCL edge is treated as ordinary data movement.
  logic w_scl_rise, w_scl_fall, w_scl_high, w_start, w_stop;

  assign w_scl_rise = scl_sync_q & ~scl_prev_q;
  assign w_scl_fall = ~scl_sync_q & scl_prev_q;
  assign w_scl_high = scl_sync_q & scl_prev_q;
  assign w_start    = w_scl_high & sda_prev_q & ~sda_sync_q;
  assign w_stop     = w_scl_high & ~sda_prev_q & sda_sync_q;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t                     state_q,    state_d;
  logic [2:0]                 bit_cnt_q,  bit_cnt_d;
  logic [6:0]                 shift_q,    shift_d;
  logic [BCW-1:0]             byte_cnt_q, byte_cnt_d;
  logic [AXIS_DATA_WIDTH-1:0] asm_q,      asm_d;
  logic                       ack_on_q,   ack_on_d;
  logic                       sda_oe_q,   sda_oe_d;
  logic                       busy_q,     busy_d;
  logic                       err_q,      err_d;
  logic                       tvalid_q,   tvalid_d;
  logic [AXIS_DATA_WIDTH-1:0] tdata_q,    tdata_d;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      byte_cnt_q <= '0;
      asm_q      <= '0;
      ack_on_q   <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      tvalid_q   <= 1'b0;
      tdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      ack_on_q   <= ack_on_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      tvalid_q   <= tvalid_d;
      tdata_q    <= tdata_d;
    end
  end

  // The byte completing on this SCL rise (7 bits already shifted + current SDA).
  logic [7:0] w_byte;
  assign w_byte = {shift_q, sda_sync_q};

  // Assembly register with w_byte dropped into slot (N-1-byte_cnt); byte 0 of
  // a word therefore lands in the MSBs.
  logic [AXIS_DATA_WIDTH-1:0] w_asm_fill;

  always_comb begin
    w_asm_fill = asm_q;
    for (int k = 0; k < NBYTES; k++) begin
      if (byte_cnt_q == BCW'(NBYTES - 1 - k)) begin
        w_asm_fill[k*8 +: 8] = w_byte;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state / output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    ack_on_d   = ack_on_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    err_d      = 1'b0;
    tdata_d    = tdata_q;
    // Output register drains independently of the bus state.
    tvalid_d   = tvalid_q & ~m_axis_tready;

    if (w_start || w_stop) begin
      // Bus conditions override any edge processing in the same cycle.
      state_d    = w_start ? S_ADDR : S_IDLE;
      bit_cnt_d  = '0;
      byte_cnt_d = '0;
      ack_on_d   = 1'b0;
      sda_oe_d   = 1'b0;
      busy_d     = 1'b0;
      if (byte_cnt_q != '0) begin
        err_d = 1'b1;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
        end

        S_ADDR: begin
          if (w_scl_rise) begin
            shift_d = w_byte[6:0];
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_d = '0;
              if ((w_byte[7:1] == TARGET_ADDR) && !w_byte[0]) begin
                state_d = S_ADDR_ACK;
                busy_d  = 1'b1;
              end else begin
                state_d = S_IGNORE;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
        end

        // First SCL fall after bit 8 pulls SDA low; the fall that ends the
        // 9th clock releases it and hands the bus back for the next byte.
        S_ADDR_ACK, S_DATA_ACK: begin
          if (w_scl_fall) begin
            if (!ack_on_q) begin
              sda_oe_d = 1'b1;
              ack_on_d = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              ack_on_d  = 1'b0;
              bit_cnt_d = '0;
              state_d   = S_DATA;
            end
          end
        end

        S_DATA: begin
          if (w_scl_rise) begin
            shift_d = w_byte[6:0];
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_d = '0;
              if (byte_cnt_q != LAST_BYTE) begin
                asm_d      = w_asm_fill;
                byte_cnt_d = byte_cnt_q + BCW'(1);
                state_d    = S_DATA_ACK;
              end else if (!tvalid_q || m_axis_tready) begin
                tdata_d    = w_asm_fill;
                tvalid_d   = 1'b1;
                byte_cnt_d = '0;
                state_d    = S_DATA_ACK;
              end else begin
                // Output still held: drop the whole word and NACK it.
                err_d      = 1'b1;
                byte_cnt_d = '0;
                state_d    = S_IGNORE;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
        end

        S_IGNORE: begin
          sda_oe_d = 1'b0;
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign sda_oe        = sda_oe_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign busy          = busy_q;
  assign err           = err_q;

endmodule

`default_nettype wire

// File: tb/tb_i2c_axis_target.sv
//==============================================================================
// Module   : tb_i2c_axis_target
// Purpose  : Self-checking bench for i2c_axis_target (N=2). A bus-master model
//            issues directed transactions; expected words are queued when the
//            stimulus is issued and a negedge monitor compares every beat.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_i2c_axis_target;

  localparam int W = 16;
  localparam int Q = 10;   // quarter SCL period in clk cycles (SCL = clk/40)

  logic         clk = 1'b0;
  logic         arst = 1'b1;
  logic         scl_m = 1'b1;
  logic         sda_m = 1'b1;
  logic         m_axis_tready = 1'b0;
  logic         sda_oe;
  logic         m_axis_tvalid;
  logic [W-1:0] m_axis_tdata;
  logic         busy;
  logic         err;
  logic         sda_bus;

  // Open-drain wired-AND of master and target.
  assign sda_bus = sda_m & ~sda_oe;

  i2c_axis_target #(
    .TARGET_ADDR    (7'h50),
    .AXIS_DATA_WIDTH(W)
  ) dut (
    .clk          (clk),
    .arst         (arst),
    .scl_i        (scl_m),
    .sda_i        (sda_bus),
    .sda_oe       (sda_oe),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .busy         (busy),
    .err          (err)
  );

  initial forever #5 clk = ~clk;

  int           n_checks  = 0;
  int           n_errors  = 0;
  int           beats     = 0;
  int           err_cnt   = 0;
  bit           oe_seen   = 1'b0;
  bit           busy_seen = 1'b0;
  logic [W-1:0] exp_q[$];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Scoreboard monitor: samples on the falling edge, away from the DUT edge.
  initial forever begin
    @(negedge clk);
    if (!arst) begin
      if (sda_oe) oe_seen = 1'b1;
      if (busy)   busy_seen = 1'b1;
      if (err)    err_cnt++;
      if (m_axis_tvalid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_beat: got tvalid=1 tdata=%0h expected no beat", m_axis_tdata);
        end else if (m_axis_tready) begin
          chk("beat_data", 32'(m_axis_tdata), 32'(exp_q.pop_front()));
          beats++;
        end else begin
          chk("held_data", 32'(m_axis_tdata), 32'(exp_q[0]));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;    tick(Q);
    scl_m = 1'b1; tick(2*Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    ack = ~sda_bus;
    tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic wr(input logic [7:0] b, input logic exp_ack, input string name);
    logic a;
    send_byte(b, a);
    chk(name, 32'(a), 32'(exp_ack));
  endtask

  int b0, e0;

  initial begin
    // ---------------- reset state ----------------
    tick(3);
    chk("rst_sda_oe", 32'(sda_oe), 0);
    chk("rst_tvalid", 32'(m_axis_tvalid), 0);
    chk("rst_tdata",  32'(m_axis_tdata), 0);
    chk("rst_busy",   32'(busy), 0);
    chk("rst_err",    32'(err), 0);
    arst = 1'b0;
    tick(5);

    // ---------------- basic write ----------------
    m_axis_tready = 1'b1;
    b0 = beats; e0 = err_cnt;
    exp_q.push_back(16'h1234);
    i2c_start();
    chk("basic_busy_pre", 32'(busy), 0);
    wr(8'hA0, 1'b1, "basic_ack_addr");
    chk("basic_busy_on", 32'(busy), 1);
    wr(8'h12, 1'b1, "basic_ack_d0");
    wr(8'h34, 1'b1, "basic_ack_d1");
    chk("basic_busy_mid", 32'(busy), 1);
    i2c_stop();
    tick(5);
    chk("basic_busy_off", 32'(busy), 0);
    chk("basic_beats", 32'(beats - b0), 1);
    chk("basic_err", 32'(err_cnt - e0), 0);

    // ---------------- address mismatch ----------------
    b0 = beats; oe_seen = 1'b0; busy_seen = 1'b0;
    i2c_start();
    wr(8'hA2, 1'b0, "mismatch_nack_addr");
    wr(8'h55, 1'b0, "mismatch_nack_data");
    i2c_stop();
    tick(5);
    chk("mismatch_oe_seen", 32'(oe_seen), 0);
    chk("mismatch_busy_seen", 32'(busy_seen), 0);
    chk("mismatch_beats", 32'(beats - b0), 0);

    // ---------------- read request ----------------
    b0 = beats;
    i2c_start();
    wr(8'hA1, 1'b0, "read_nack");
    chk("read_busy", 32'(busy), 0);
    i2c_stop();
    tick(5);
    chk("read_beats", 32'(beats - b0), 0);

    // ---------------- backpressure ----------------
    m_axis_tready = 1'b0;
    b0 = beats; e0 = err_cnt;
    exp_q.push_back(16'h1122);
    i2c_start();
    wr(8'hA0, 1'b1, "bp_ack_addr");
    wr(8'h11, 1'b1, "bp_ack_b1");
    wr(8'h22, 1'b1, "bp_ack_b2");
    wr(8'h33, 1'b1, "bp_ack_b3");
    wr(8'h44, 1'b0, "bp_nack_b4");
    i2c_stop();
    tick(5);
    chk("bp_err", 32'(err_cnt - e0), 1);
    chk("bp_tvalid_held", 32'(m_axis_tvalid), 1);
    chk("bp_tdata_held", 32'(m_axis_tdata), 32'h1122);
    m_axis_tready = 1'b1;
    tick(2);
    chk("bp_tvalid_drained", 32'(m_axis_tvalid), 0);
    chk("bp_beats", 32'(beats - b0), 1);

    // ---------------- partial word + repeated START ----------------
    b0 = beats; e0 = err_cnt;
    exp_q.push_back(16'hCDEF);
    i2c_start();
    wr(8'hA0, 1'b1, "rs_ack_addr1");
    wr(8'hAB, 1'b1, "rs_ack_partial");
    i2c_start();
    chk("rs_err_at_start", 32'(err_cnt - e0), 1);
    wr(8'hA0, 1'b1, "rs_ack_addr2");
    wr(8'hCD, 1'b1, "rs_ack_d0");
    wr(8'hEF, 1'b1, "rs_ack_d1");
    i2c_stop();
    tick(5);
    chk("rs_err_total", 32'(err_cnt - e0), 1);
    chk("rs_beats", 32'(beats - b0), 1);

    // ---------------- reset mid-byte ----------------
    m_axis_tready = 1'b0;
    exp_q.push_back(16'h5566);
    i2c_start();
    wr(8'hA0, 1'b1, "rm_ack_addr1");
    wr(8'h55, 1'b1, "rm_ack_d0");
    wr(8'h66, 1'b1, "rm_ack_d1");
    i2c_stop();
    tick(5);
    chk("rm_pending_tdata", 32'(m_axis_tdata), 32'h5566);
    i2c_start();
    wr(8'hA0, 1'b1, "rm_ack_addr2");
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    chk("rm_busy_before", 32'(busy), 1);
    arst = 1'b1;
    #1;
    chk("rm_sda_oe", 32'(sda_oe), 0);
    chk("rm_tvalid", 32'(m_axis_tvalid), 0);
    chk("rm_tdata",  32'(m_axis_tdata), 0);
    chk("rm_busy",   32'(busy), 0);
    chk("rm_err",    32'(err), 0);
    exp_q.delete();
    sda_m = 1'b1;
    tick(3);
    arst = 1'b0;
    tick(5);
    m_axis_tready = 1'b1;
    b0 = beats; e0 = err_cnt;
    exp_q.push_back(16'hABCD);
    i2c_start();
    wr(8'hA0, 1'b1, "rm_ack_addr3");
    wr(8'hAB, 1'b1, "rm_ack_d2");
    wr(8'hCD, 1'b1, "rm_ack_d3");
    i2c_stop();
    tick(10);
    chk("rm_beats", 32'(beats - b0), 1);
    chk("rm_err_after", 32'(err_cnt - e0), 0);

    tick(20);
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/i2c_axis_target.md
# i2c_axis_target

I2C target (slave) receiver that is the bus-side counterpart of the AXI-Stream-to-I2C transmitter. It watches an I2C bus, responds to write transactions addressed to `TARGET_ADDR`, and packs received data bytes into AXI-Stream words on `m_axis_*` for the downstream FIFO. It drives SDA only as an open-drain acknowledge and never drives SCL.

## Interface
- `TARGET_ADDR`, default 7'h50: 7-bit address this target answers.
- `AXIS_DATA_WIDTH`, default 16: output word width. Must be a multiple of 8 and at least 8. Bytes per word is N = AXIS_DATA_WIDTH/8.
- `clk` input, 1 bit: system clock. Must run at 16× the SCL rate or faster.
- `arst` input, 1 bit: reset, asynchronous, active-high.
- `scl_i` input, 1 bit: raw SCL from the pad, asynchronous to `clk`.
- `sda_i` input, 1 bit: raw SDA from the pad, asynchronous to `clk`.
- `sda_oe` output, 1 bit: 1 pulls SDA low; 0 releases it.
- `m_axis_tvalid` output, 1 bit: output word valid.
- `m_axis_tready` input, 1 bit: downstream ready.
- `m_axis_tdata` output, AXIS_DATA_WIDTH bits: received word; the first received byte occupies the MSBs.
- `busy` output, 1 bit: high from an addressed START until the STOP.
- `err` output, 1 bit: one-cycle pulse on an overflow NACK or on a discarded partial word.

## Operation
- **Input synchronisation.** `scl_i` and `sda_i` each pass through a 2-FF synchroniser plus one history register.
  - These registers reset to 1 (idle bus), so no false START occurs after reset.
  - All detection uses the synchronised values.
- **Bus events** (all detected from the synchronised signals):
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - rise and fall: SCL edges.
- **State machine.** States: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
  - **IDLE**: a START moves to ADDR; bit counter and byte counter are cleared.
  - **ADDR**: shift SDA in, MSB first, on each SCL rise. After 8 bits:
    - if addr[7:1]==TARGET_ADDR and R/W==0, go to ADDR_ACK;
    - otherwise go to IGNORE, with no ACK.
  - **ADDR_ACK**: assert `sda_oe` on the SCL fall after bit 8. Release it on the next SCL fall (end of the 9th clock), then go to DATA. `busy` is set on entry.
  - **DATA**: shift 8 bits. On the 8th rise the byte goes into slot (N-1-byte_cnt) of the assembly register.
    - If it is not the final byte of a word: go to DATA_ACK with ACK.
    - If it is the final byte and the output register is empty, or `m_axis_tready` is high this cycle: load the word into the output register, set `m_axis_tvalid`, go to DATA_ACK with ACK, and reset byte_cnt.
    - If it is the final byte and the output register is held (tvalid=1 and tready=0): discard the word, pulse `err`, and go to IGNORE with no ACK.
  - **DATA_ACK**: same `sda_oe` timing as ADDR_ACK, then return to DATA.
  - **IGNORE**: `sda_oe`=0. Wait for START (go to ADDR) or STOP (go to IDLE).
- **Event priority.** START or STOP is honoured in every state and overrides edge processing in the same cycle.
  - STOP goes to IDLE; a repeated START goes to ADDR.
  - Both release `sda_oe` and clear `busy` (a START re-sets `busy` on the next address ACK).
  - If byte_cnt≠0 at that moment, the partial word is discarded and `err` pulses once.
- **Output register.** It is independent of the bus state.
  - `m_axis_tvalid` stays high until it is accepted by tready.
  - `m_axis_tdata` is stable while tvalid=1.
  - A STOP or START never clears a pending word.
- **Open-drain rule.** `sda_oe` is only ever asserted during an ACK bit. It changes only on a detected SCL fall or on START/STOP.

## Timing
- **Reset values:** `sda_oe`=0, `m_axis_tvalid`=0, `m_axis_tdata`=0, `busy`=0, `err`=0, state=IDLE.
- **Detection latency:** a pad edge is detected 3 clk cycles after it occurs (2 synchroniser stages plus 1 edge-compare stage).
- **Data output:** `m_axis_tvalid` rises 1 clk after the 8th SCL rise of the final byte is detected, so at most 4 clk cycles after the pad edge.
- **ACK output:** `sda_oe` changes 1 clk after a detected SCL fall, which still lands within SCL low time at 16× oversampling.
- **Stream handshake:** a transfer occurs when tvalid&tready. At one byte per 9 SCL periods, the output accepts one word per N·9 SCL periods with no loss.
- **`err`:** exactly 1 clk wide per event.
- **`arst` mid-transfer:** all outputs return to reset values immediately. Any word held in the output register is lost, and the bus is released.

## Test plan
- **Basic write:** with N=2, send START, 0xA0, 0x12, 0x34, STOP with tready=1. Required: ACK on all 3 bytes, one beat with tdata=0x1234, `busy` high from the address ACK to STOP, `err` never set.
- **Address mismatch:** send START, 0xA2, 0x55, STOP. Required: `sda_oe` never asserted, no beat, `busy`=0 throughout.
- **Read request:** send START, 0xA1. Required: NACK, state IGNORE, then IDLE after STOP, no beat.
- **Backpressure:** hold tready=0 and write 0x11 0x22 0x33 0x44. Required:
  - bytes 1–3 are ACKed and the beat 0x1122 is held stable;
  - byte 4 is NACKed, `err` pulses once, and there is no second beat.
  - Then raise tready: 0x1122 transfers in one cycle.
- **Partial word and repeated START:** write 0xAB, then repeated START, 0xA0, 0xCD, 0xEF, STOP. Required: `err` pulse at the repeated START, single beat 0xCDEF.
- **Reset mid-byte:** assert `arst` during the 5th data bit. Required: all outputs are 0 in the same cycle, and a following clean 2-byte write yields a correct beat.
